// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the DDR PLL: pulses pll_rst, waits for a stable synced lock,
// opens the clkout0 gate and then flags pll_ready; retries on lock timeout up to MAX_RETRY.
module pll_lock_sequencer #(
  parameter int RST_CYCLES          = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int GATE_DELAY_CYCLES   = 16,
  parameter int MAX_RETRY           = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           soft_rst,
  input  logic                           pll_lock,
  output logic                           pll_rst,
  output logic                           clkout0_gate,
  output logic                           pll_ready,
  output logic                           lock_lost,
  output logic                           lock_err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0]                     state
);

  localparam int RW      = $clog2(MAX_RETRY + 1);
  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > GATE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : GATE_DELAY_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    RST_ASSERT  = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    GATE_DELAY  = 3'd3,
    RUN         = 3'd4,
    FAIL        = 3'd5
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   retry_reg;
  logic            lock_meta_reg;
  logic            lock_s_reg;
  logic            pll_rst_reg;
  logic            gate_reg;
  logic            ready_reg;
  logic            lock_lost_reg;
  logic            lock_err_reg;

  assign pll_rst      = pll_rst_reg;
  assign clkout0_gate = gate_reg;
  assign pll_ready    = ready_reg;
  assign lock_lost    = lock_lost_reg;
  assign lock_err     = lock_err_reg;
  assign retry_cnt    = retry_reg;
  assign state        = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RST_ASSERT;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
      pll_rst_reg   <= 1'b1;
      gate_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      lock_lost_reg <= 1'b0;
      lock_err_reg  <= 1'b0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
      lock_lost_reg <= 1'b0;
      cnt_reg       <= cnt_reg + CW'(1);

      if (soft_rst) begin
        state_reg    <= RST_ASSERT;
        cnt_reg      <= '0;
        retry_reg    <= '0;
        lock_err_reg <= 1'b0;
        pll_rst_reg  <= 1'b1;
        gate_reg     <= 1'b0;
        ready_reg    <= 1'b0;
      end else begin
        case (state_reg)
          RST_ASSERT: begin
            if (cnt_reg == CW'(RST_CYCLES - 1)) begin
              state_reg   <= WAIT_LOCK;
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b0;
            end
          end
          WAIT_LOCK: begin
            if (lock_s_reg) begin
              state_reg <= LOCK_STABLE;
              cnt_reg   <= '0;
            end else if (cnt_reg == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b1;
              if (retry_reg == RW'(MAX_RETRY)) begin
                state_reg    <= FAIL;
                lock_err_reg <= 1'b1;
              end else begin
                state_reg <= RST_ASSERT;
                retry_reg <= retry_reg + RW'(1);
              end
            end
          end
          LOCK_STABLE: begin
            if (!lock_s_reg) begin
              state_reg <= WAIT_LOCK;
              cnt_reg   <= '0;
            end else if (cnt_reg == CW'(LOCK_STABLE_CYCLES - 1)) begin
              state_reg <= GATE_DELAY;
              cnt_reg   <= '0;
              gate_reg  <= 1'b1;
            end
          end
          GATE_DELAY: begin
            if (!lock_s_reg) begin
              state_reg     <= RST_ASSERT;
              cnt_reg       <= '0;
              pll_rst_reg   <= 1'b1;
              gate_reg      <= 1'b0;
              lock_lost_reg <= 1'b1;
            end else if (cnt_reg == CW'(GATE_DELAY_CYCLES - 1)) begin
              state_reg <= RUN;
              cnt_reg   <= '0;
              ready_reg <= 1'b1;
            end
          end
          RUN: begin
            cnt_reg <= '0;
            if (!lock_s_reg) begin
              state_reg     <= RST_ASSERT;
              retry_reg     <= '0;
              pll_rst_reg   <= 1'b1;
              gate_reg      <= 1'b0;
              ready_reg     <= 1'b0;
              lock_lost_reg <= 1'b1;
            end
          end
          FAIL: begin
            // Parked with the PLL held in reset until soft_rst or rst_n
            cnt_reg      <= '0;
            pll_rst_reg  <= 1'b1;
            lock_err_reg <= 1'b1;
            gate_reg     <= 1'b0;
            ready_reg    <= 1'b0;
          end
          default: begin
            state_reg   <= RST_ASSERT;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            gate_reg    <= 1'b0;
            ready_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with shortened timing parameters;
// expected latencies and output snapshots are queued, then popped when the DUT responds.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int LT    = 32;
  localparam int LS    = 8;
  localparam int GD    = 2;
  localparam int MR    = 2;
  localparam int RW    = $clog2(MR + 1);
  localparam int LIMIT = 200;

  localparam int S_RST   = 0;
  localparam int S_GATE  = 1;
  localparam int S_READY = 2;
  localparam int S_LOST  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soft_rst = 1'b0;
  logic          pll_lock = 1'b0;
  logic          pll_rst;
  logic          clkout0_gate;
  logic          pll_ready;
  logic          lock_lost;
  logic          lock_err;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state;

  typedef struct {
    string name;
    int    value;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT_CYCLES(LT), .LOCK_STABLE_CYCLES(LS),
    .GATE_DELAY_CYCLES(GD), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .clkout0_gate(clkout0_gate), .pll_ready(pll_ready),
    .lock_lost(lock_lost), .lock_err(lock_err), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      S_RST:   return pll_rst;
      S_GATE:  return clkout0_gate;
      S_READY: return pll_ready;
      S_LOST:  return lock_lost;
      default: return 1'b0;
    endcase
  endfunction

  // Counts clock edges until the selected output reaches val (LIMIT means it never did)
  task automatic edges_until(input int which, input logic val, output int n);
    n = 0;
    while (sig_of(which) !== val && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    sb.push_back('{"reset_outputs", int'(10'b1_0_0_0_0_00_000)});
    e = sb.pop_front(); checks++;
    if (int'({pll_rst, clkout0_gate, pll_ready, lock_lost, lock_err, retry_cnt, state}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name,
               int'({pll_rst, clkout0_gate, pll_ready, lock_lost, lock_err, retry_cnt, state}), e.value);
    end
  endtask

  task automatic test_lock_sequence();
    int n, m;
    sb.push_back('{"first_rst_hold", RST_C});
    rst_n = 1'b1;
    edges_until(S_RST, 1'b0, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    repeat (5) tick();
    sb.push_back('{"gate_after_lock", 3 + LS});
    sb.push_back('{"ready_after_lock", 3 + LS + GD});
    pll_lock = 1'b1;
    edges_until(S_GATE, 1'b1, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    edges_until(S_READY, 1'b1, m);
    e = sb.pop_front(); checks++;
    if (n + m !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n + m, e.value); end
    sb.push_back('{"run_state_retry", int'({2'b00, 3'd4})});
    e = sb.pop_front(); checks++;
    if (int'({retry_cnt, state}) !== e.value) begin
      errors++; $display("FAIL %s: got %0d expected %0d", e.name, int'({retry_cnt, state}), e.value);
    end
  endtask

  task automatic test_run_lock_loss();
    int n, pulses;
    sb.push_back('{"lock_lost_latency", 3});
    sb.push_back('{"loss_outputs", int'(6'b0_0_1_000)});
    sb.push_back('{"loss_rst_hold", RST_C});
    sb.push_back('{"lock_lost_pulses", 1});
    pll_lock = 1'b0;
    edges_until(S_LOST, 1'b1, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    e = sb.pop_front(); checks++;
    if (int'({clkout0_gate, pll_ready, pll_rst, state}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name, int'({clkout0_gate, pll_ready, pll_rst, state}), e.value);
    end
    pulses = lock_lost ? 1 : 0;
    n = 0;
    while (pll_rst === 1'b1 && n < LIMIT) begin
      tick();
      n++;
      if (lock_lost) pulses++;
    end
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    e = sb.pop_front(); checks++;
    if (pulses !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, pulses, e.value); end
  endtask

  task automatic test_timeout_retry();
    int n;
    for (int i = 1; i <= MR; i++) begin
      sb.push_back('{$sformatf("timeout_gap_%0d", i), LT});
      sb.push_back('{$sformatf("retry_cnt_%0d", i), i});
      sb.push_back('{$sformatf("retry_rst_hold_%0d", i), RST_C});
      edges_until(S_RST, 1'b1, n);
      e = sb.pop_front(); checks++;
      if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
      e = sb.pop_front(); checks++;
      if (int'(retry_cnt) !== e.value) begin
        errors++; $display("FAIL %s: got %0d expected %0d", e.name, retry_cnt, e.value);
      end
      edges_until(S_RST, 1'b0, n);
      e = sb.pop_front(); checks++;
      if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    end
    sb.push_back('{"final_timeout_gap", LT});
    sb.push_back('{"fail_entry", int'(9'b1_1_0_0_10_101)});
    sb.push_back('{"fail_parked", int'(9'b1_1_0_0_10_101)});
    edges_until(S_RST, 1'b1, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    e = sb.pop_front(); checks++;
    if (int'({pll_rst, lock_err, clkout0_gate, pll_ready, retry_cnt, state}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name,
               int'({pll_rst, lock_err, clkout0_gate, pll_ready, retry_cnt, state}), e.value);
    end
    repeat (10) tick();
    e = sb.pop_front(); checks++;
    if (int'({pll_rst, lock_err, clkout0_gate, pll_ready, retry_cnt, state}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name,
               int'({pll_rst, lock_err, clkout0_gate, pll_ready, retry_cnt, state}), e.value);
    end
    sb.push_back('{"soft_rst_clear", int'(8'b0_00_000_1_0_0)});
    sb.push_back('{"soft_rst_hold", RST_C});
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    e = sb.pop_front(); checks++;
    if (int'({lock_err, retry_cnt, state, pll_rst, clkout0_gate, pll_ready}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name,
               int'({lock_err, retry_cnt, state, pll_rst, clkout0_gate, pll_ready}), e.value);
    end
    edges_until(S_RST, 1'b0, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
  endtask

  task automatic test_stable_glitch();
    int n, m;
    sb.push_back('{"stable_entry", 3});
    sb.push_back('{"gate_after_glitch", 3 + LS});
    sb.push_back('{"ready_after_gate", GD});
    pll_lock = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < LIMIT) begin tick(); n++; end
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    edges_until(S_GATE, 1'b1, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    edges_until(S_READY, 1'b1, m);
    e = sb.pop_front(); checks++;
    if (m !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, m, e.value); end
  endtask

  task automatic test_async_reset();
    int n, m;
    sb.push_back('{"soft_rst_in_run", int'(8'b0_00_000_1_0_0)});
    sb.push_back('{"async_reset_outputs", int'(10'b1_0_0_0_0_00_000)});
    sb.push_back('{"restart_gate", 1 + RST_C + LS});
    sb.push_back('{"restart_ready", 1 + RST_C + LS + GD});
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    e = sb.pop_front(); checks++;
    if (int'({lock_err, retry_cnt, state, pll_rst, clkout0_gate, pll_ready}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name,
               int'({lock_err, retry_cnt, state, pll_rst, clkout0_gate, pll_ready}), e.value);
    end
    edges_until(S_GATE, 1'b1, n);
    #2 rst_n = 1'b0;
    #1;
    e = sb.pop_front(); checks++;
    if (int'({pll_rst, clkout0_gate, pll_ready, lock_lost, lock_err, retry_cnt, state}) !== e.value) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", e.name,
               int'({pll_rst, clkout0_gate, pll_ready, lock_lost, lock_err, retry_cnt, state}), e.value);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    edges_until(S_GATE, 1'b1, n);
    e = sb.pop_front(); checks++;
    if (n !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.value); end
    edges_until(S_READY, 1'b1, m);
    e = sb.pop_front(); checks++;
    if (n + m !== e.value) begin errors++; $display("FAIL %s: got %0d expected %0d", e.name, n + m, e.value); end
  endtask

  task automatic test_random_glitches();
    int n;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      checks++;
      if (pll_ready === 1'b1 && (clkout0_gate !== 1'b1 || pll_rst !== 1'b0)) begin
        errors++;
        $display("FAIL inv_ready cycle %0d: got gate=%b rst=%b expected gate=1 rst=0", i, clkout0_gate, pll_rst);
      end
      checks++;
      if (clkout0_gate === 1'b1 && pll_rst !== 1'b0) begin
        errors++;
        $display("FAIL inv_gate_rst cycle %0d: got rst=%b expected 0 while gated", i, pll_rst);
      end
      #($urandom_range(1, 4));
      pll_lock = ($urandom_range(0, 15) != 0);
    end
    sb.push_back('{"recover_to_run", 1});
    pll_lock = 1'b1;
    tick();
    edges_until(S_READY, 1'b1, n);
    e = sb.pop_front(); checks++;
    if (int'(n < LIMIT && state === 3'd4) !== e.value) begin
      errors++; $display("FAIL %s: got %0d expected %0d", e.name, int'(n < LIMIT && state === 3'd4), e.value);
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_run_lock_loss();
    test_timeout_retry();
    test_stable_glitch();
    test_async_reset();
    test_random_glitches();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
